// File: rtl/spu_pkg.sv
// spu_pkg: definitions shared by the SPU register-fetch slice.
//   Widths: WORD_W (operand/result word), ADDR_W (register address),
//           OP_W / IMM_W / FMT_W (decoded instruction fields).
//   OP_NOP:    opcode value that marks an empty slot.
//   fwd_tap_t: one execution-stage result tap (data, destination, valid).
//   addr_hit:  enable-qualified register address compare.
package spu_pkg;

    localparam int WORD_W = 128;
    localparam int ADDR_W = 7;
    localparam int OP_W   = 11;
    localparam int IMM_W  = 18;
    localparam int FMT_W  = 3;

    localparam logic [OP_W-1:0] OP_NOP = '0;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              valid;
    } fwd_tap_t;

    function automatic logic addr_hit(input logic              en,
                                      input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/reg_file_128x128.sv
// reg_file_128x128: architectural register file, REG_COUNT x 128 bits.
//   clk, reset (async, active-low): reset zeroes every entry.
//   we_even/wa_even/wd_even: even-pipe write port.
//   we_odd/wa_odd/wd_odd:    odd-pipe write port; wins an address conflict.
//   rd_addr[3] / rd_data[3]: three combinational read ports (RA, RB, RC).
// Register 0 is an ordinary register.
module reg_file_128x128
    import spu_pkg::*;
#(
    parameter int REG_COUNT = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_even,
    input  logic [ADDR_W-1:0] wa_even,
    input  logic [WORD_W-1:0] wd_even,
    input  logic              we_odd,
    input  logic [ADDR_W-1:0] wa_odd,
    input  logic [WORD_W-1:0] wd_odd,
    input  logic [ADDR_W-1:0] rd_addr [3],
    output logic [WORD_W-1:0] rd_data [3]
);

    logic [WORD_W-1:0] mem [REG_COUNT];

    // Odd port is written second so its non-blocking update wins a conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we_even) begin
                mem[wa_even] <= wd_even;
            end
            if (we_odd) begin
                mem[wa_odd] <= wd_odd;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            rd_data[r] = mem[rd_addr[r]];
        end
    end

endmodule

// File: rtl/register_fetch.sv
// register_fetch: SPU register-fetch / forward stage.
//   clk, reset (async, active-low): clears the register file and outputs.
//   op_in, format_in, imm_in, rt_addr_in, reg_write_in: decoded instruction.
//   ra_addr_in, rb_addr_in, rc_addr_in: source register addresses.
//   stall: hold the output bundle; flush: load a NOP (overrides stall).
//   fwd_data/fwd_addr/fwd_valid[FWD_DEPTH]: execution result taps, 0 youngest.
//   rt_wb_*/rt_addr_wb_*/reg_write_wb_* (even, odd): write-back ports.
//   op, format, rt_addr, imm, reg_write, ra, rb, rc: registered bundle to
//   execute, one cycle after the inputs were sampled.
module register_fetch
    import spu_pkg::*;
#(
    parameter int FWD_DEPTH = 7,
    parameter int REG_COUNT = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op_in,
    input  logic [FMT_W-1:0]  format_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [ADDR_W-1:0] rt_addr_in,
    input  logic [ADDR_W-1:0] ra_addr_in,
    input  logic [ADDR_W-1:0] rb_addr_in,
    input  logic [ADDR_W-1:0] rc_addr_in,
    input  logic              reg_write_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] fwd_data  [FWD_DEPTH],
    input  logic [ADDR_W-1:0] fwd_addr  [FWD_DEPTH],
    input  logic              fwd_valid [FWD_DEPTH],
    input  logic [WORD_W-1:0] rt_wb_even,
    input  logic [WORD_W-1:0] rt_wb_odd,
    input  logic [ADDR_W-1:0] rt_addr_wb_even,
    input  logic [ADDR_W-1:0] rt_addr_wb_odd,
    input  logic              reg_write_wb_even,
    input  logic              reg_write_wb_odd,
    output logic [OP_W-1:0]   op,
    output logic [FMT_W-1:0]  format,
    output logic [ADDR_W-1:0] rt_addr,
    output logic [IMM_W-1:0]  imm,
    output logic              reg_write,
    output logic [WORD_W-1:0] ra,
    output logic [WORD_W-1:0] rb,
    output logic [WORD_W-1:0] rc
);

    fwd_tap_t          taps     [FWD_DEPTH];
    logic [ADDR_W-1:0] src_addr [3];
    logic [WORD_W-1:0] rf_rd    [3];
    logic [WORD_W-1:0] opnd_p0  [3];

    always_comb begin
        for (int t = 0; t < FWD_DEPTH; t++) begin
            taps[t].data  = fwd_data[t];
            taps[t].addr  = fwd_addr[t];
            taps[t].valid = fwd_valid[t];
        end
    end

    always_comb begin
        src_addr[0] = ra_addr_in;
        src_addr[1] = rb_addr_in;
        src_addr[2] = rc_addr_in;
    end

    reg_file_128x128 #(
        .REG_COUNT (REG_COUNT)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we_even (reg_write_wb_even),
        .wa_even (rt_addr_wb_even),
        .wd_even (rt_wb_even),
        .we_odd  (reg_write_wb_odd),
        .wa_odd  (rt_addr_wb_odd),
        .wd_odd  (rt_wb_odd),
        .rd_addr (src_addr),
        .rd_data (rf_rd)
    );

    // Stage p0: operand resolution. Sources are layered lowest priority
    // first, so each later assignment overrides: RF, even WB, odd WB, then
    // taps from oldest to youngest so the lowest-index matching tap wins.
    // The WB bypass makes a same-edge write visible to this capture.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            opnd_p0[s] = rf_rd[s];
            if (addr_hit(reg_write_wb_even, rt_addr_wb_even, src_addr[s])) begin
                opnd_p0[s] = rt_wb_even;
            end
            if (addr_hit(reg_write_wb_odd, rt_addr_wb_odd, src_addr[s])) begin
                opnd_p0[s] = rt_wb_odd;
            end
            for (int t = FWD_DEPTH - 1; t >= 0; t--) begin
                if (addr_hit(taps[t].valid, taps[t].addr, src_addr[s])) begin
                    opnd_p0[s] = taps[t].data;
                end
            end
        end
    end

    // Stage p1: output bundle register. Held operands are not re-resolved
    // under stall; the hazard unit keeps them valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op        <= OP_NOP;
            format    <= '0;
            rt_addr   <= '0;
            imm       <= '0;
            reg_write <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
        end else if (flush) begin
            op        <= OP_NOP;
            format    <= '0;
            rt_addr   <= '0;
            imm       <= '0;
            reg_write <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
        end else if (!stall) begin
            op        <= op_in;
            format    <= format_in;
            rt_addr   <= rt_addr_in;
            imm       <= imm_in;
            reg_write <= reg_write_in;
            ra        <= opnd_p0[0];
            rb        <= opnd_p0[1];
            rc        <= opnd_p0[2];
        end
    end

endmodule

// File: tb/tb_register_fetch.sv
module tb_register_fetch;
    import spu_pkg::*;

    localparam int FWD_DEPTH = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [OP_W-1:0]   op_in;
    logic [FMT_W-1:0]  format_in;
    logic [IMM_W-1:0]  imm_in;
    logic [ADDR_W-1:0] rt_addr_in, ra_addr_in, rb_addr_in, rc_addr_in;
    logic              reg_write_in, stall, flush;
    logic [WORD_W-1:0] fwd_data  [FWD_DEPTH];
    logic [ADDR_W-1:0] fwd_addr  [FWD_DEPTH];
    logic              fwd_valid [FWD_DEPTH];
    logic [WORD_W-1:0] rt_wb_even, rt_wb_odd;
    logic [ADDR_W-1:0] rt_addr_wb_even, rt_addr_wb_odd;
    logic              reg_write_wb_even, reg_write_wb_odd;
    logic [OP_W-1:0]   op;
    logic [FMT_W-1:0]  format;
    logic [ADDR_W-1:0] rt_addr;
    logic [IMM_W-1:0]  imm;
    logic              reg_write;
    logic [WORD_W-1:0] ra, rb, rc;

    register_fetch #(.FWD_DEPTH(FWD_DEPTH), .REG_COUNT(128)) dut (
        .clk(clk), .reset(reset),
        .op_in(op_in), .format_in(format_in), .imm_in(imm_in),
        .rt_addr_in(rt_addr_in), .ra_addr_in(ra_addr_in),
        .rb_addr_in(rb_addr_in), .rc_addr_in(rc_addr_in),
        .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
        .fwd_data(fwd_data), .fwd_addr(fwd_addr), .fwd_valid(fwd_valid),
        .rt_wb_even(rt_wb_even), .rt_wb_odd(rt_wb_odd),
        .rt_addr_wb_even(rt_addr_wb_even), .rt_addr_wb_odd(rt_addr_wb_odd),
        .reg_write_wb_even(reg_write_wb_even), .reg_write_wb_odd(reg_write_wb_odd),
        .op(op), .format(format), .rt_addr(rt_addr), .imm(imm),
        .reg_write(reg_write), .ra(ra), .rb(rb), .rc(rc)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents plus expected bundle.
    logic [WORD_W-1:0] model_rf [128];
    logic [OP_W-1:0]   e_op;
    logic [FMT_W-1:0]  e_fmt;
    logic [ADDR_W-1:0] e_rt;
    logic [IMM_W-1:0]  e_imm;
    logic              e_rw;
    logic [WORD_W-1:0] e_ra, e_rb, e_rc;

    int errors = 0;
    int checks = 0;

    function automatic logic [WORD_W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Value an operand read of register a should see this cycle.
    function automatic logic [WORD_W-1:0] resolve(input logic [ADDR_W-1:0] a);
        for (int t = 0; t < FWD_DEPTH; t++) begin
            if (fwd_valid[t] && fwd_addr[t] == a) return fwd_data[t];
        end
        if (reg_write_wb_odd && rt_addr_wb_odd == a) return rt_wb_odd;
        if (reg_write_wb_even && rt_addr_wb_even == a) return rt_wb_even;
        return model_rf[a];
    endfunction

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs,
                       input logic [WORD_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".op"}, WORD_W'(op), WORD_W'(e_op));
        chk({tag, ".format"}, WORD_W'(format), WORD_W'(e_fmt));
        chk({tag, ".rt_addr"}, WORD_W'(rt_addr), WORD_W'(e_rt));
        chk({tag, ".imm"}, WORD_W'(imm), WORD_W'(e_imm));
        chk({tag, ".reg_write"}, WORD_W'(reg_write), WORD_W'(e_rw));
        chk({tag, ".ra"}, ra, e_ra);
        chk({tag, ".rb"}, rb, e_rb);
        chk({tag, ".rc"}, rc, e_rc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) model_rf[i] = '0;
        e_op = '0; e_fmt = '0; e_rt = '0; e_imm = '0; e_rw = 1'b0;
        e_ra = '0; e_rb = '0; e_rc = '0;
    endtask

    task automatic clear_inputs();
        op_in = '0; format_in = '0; imm_in = '0; rt_addr_in = '0;
        ra_addr_in = '0; rb_addr_in = '0; rc_addr_in = '0;
        reg_write_in = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int t = 0; t < FWD_DEPTH; t++) begin
            fwd_data[t] = '0; fwd_addr[t] = '0; fwd_valid[t] = 1'b0;
        end
        rt_wb_even = '0; rt_wb_odd = '0; rt_addr_wb_even = '0; rt_addr_wb_odd = '0;
        reg_write_wb_even = 1'b0; reg_write_wb_odd = 1'b0;
    endtask

    // Predict the bundle for the current inputs, apply WB to the model,
    // then advance one edge and compare away from it.
    task automatic cycle(input string tag);
        logic [WORD_W-1:0] na, nb, nc;
        na = resolve(ra_addr_in);
        nb = resolve(rb_addr_in);
        nc = resolve(rc_addr_in);
        if (flush) begin
            e_op = '0; e_fmt = '0; e_rt = '0; e_imm = '0; e_rw = 1'b0;
            e_ra = '0; e_rb = '0; e_rc = '0;
        end else if (!stall) begin
            e_op = op_in; e_fmt = format_in; e_rt = rt_addr_in; e_imm = imm_in;
            e_rw = reg_write_in; e_ra = na; e_rb = nb; e_rc = nc;
        end
        if (reg_write_wb_even) model_rf[rt_addr_wb_even] = rt_wb_even;
        if (reg_write_wb_odd) model_rf[rt_addr_wb_odd] = rt_wb_odd;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    logic [WORD_W-1:0] v_one, v_a, v_b, v_c, v_d, v_e, v_r1, v_t0;

    initial begin
        v_one = {8{16'h0001}};
        v_a = rnd128(); v_b = rnd128(); v_c = rnd128();
        v_d = rnd128(); v_e = rnd128(); v_r1 = rnd128(); v_t0 = rnd128();

        // Power-on reset
        reset = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        check_all("por");
        #11 reset = 1'b1;
        @(posedge clk); #1;

        // Write r3 through even WB, then read it back
        rt_addr_wb_even = 7'd3; rt_wb_even = v_one; reg_write_wb_even = 1'b1;
        op_in = 11'h123; format_in = 3'd5; imm_in = 18'h2abcd; rt_addr_in = 7'd40;
        reg_write_in = 1'b1;
        cycle("wr_r3");
        clear_inputs();
        ra_addr_in = 7'd3; op_in = 11'h7;
        cycle("rd_r3");
        chk("rd_r3_const", ra, v_one);

        // Asynchronous reset in mid-cycle
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_ra", ra, '0);
        clear_inputs();
        #3 reset = 1'b1;
        ra_addr_in = 7'd3;
        cycle("post_rst_r3");
        chk("post_rst_r3_zero", ra, '0);

        // Same-cycle even/odd conflict with bypass
        clear_inputs();
        rt_addr_wb_even = 7'd5; rt_wb_even = v_a; reg_write_wb_even = 1'b1;
        rt_addr_wb_odd = 7'd5; rt_wb_odd = v_b; reg_write_wb_odd = 1'b1;
        rb_addr_in = 7'd5;
        cycle("conflict");
        chk("conflict_rb_B", rb, v_b);
        clear_inputs();
        rb_addr_in = 7'd5; ra_addr_in = 7'd5;
        cycle("conflict_later");
        chk("conflict_later_B", rb, v_b);

        // Forward priority: tap 1 beats tap 4 beats RF
        clear_inputs();
        rt_addr_wb_even = 7'd7; rt_wb_even = v_c; reg_write_wb_even = 1'b1;
        cycle("wr_r7");
        clear_inputs();
        ra_addr_in = 7'd7;
        fwd_addr[4] = 7'd7; fwd_data[4] = v_d; fwd_valid[4] = 1'b1;
        fwd_addr[1] = 7'd7; fwd_data[1] = v_e; fwd_valid[1] = 1'b1;
        cycle("fwd_both");
        chk("fwd_both_E", ra, v_e);
        fwd_valid[1] = 1'b0;
        cycle("fwd_tap4");
        chk("fwd_tap4_D", ra, v_d);
        fwd_valid[4] = 1'b0;
        cycle("fwd_none");
        chk("fwd_none_C", ra, v_c);

        // Stall for three cycles while r9 is written
        clear_inputs();
        op_in = 11'h55; reg_write_in = 1'b1; rt_addr_in = 7'd9; ra_addr_in = 7'd7;
        cycle("pre_stall");
        op_in = 11'h66; ra_addr_in = 7'd9; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rt_addr_wb_even = 7'd9; rt_wb_even = rnd128(); reg_write_wb_even = 1'b1;
            cycle("stall");
            chk("stall_op_held", WORD_W'(op), WORD_W'(11'h55));
            chk("stall_ra_held", ra, v_c);
        end
        clear_inputs();
        ra_addr_in = 7'd9;
        cycle("rd_r9");

        // Stall and flush together
        op_in = 11'h3ff; reg_write_in = 1'b1; stall = 1'b1; flush = 1'b1;
        cycle("stall_flush");
        chk("flush_op", WORD_W'(op), '0);
        chk("flush_rw", WORD_W'(reg_write), '0);

        // Three sources, tap 0 supplies rc
        clear_inputs();
        rt_addr_wb_odd = 7'd1; rt_wb_odd = v_r1; reg_write_wb_odd = 1'b1;
        cycle("wr_r1");
        clear_inputs();
        ra_addr_in = 7'd1; rb_addr_in = 7'd1; rc_addr_in = 7'd2;
        fwd_addr[0] = 7'd2; fwd_data[0] = v_t0; fwd_valid[0] = 1'b1;
        cycle("three_src");
        chk("three_ra", ra, v_r1);
        chk("three_rb", rb, v_r1);
        chk("three_rc", rc, v_t0);

        // Randomized traffic over a small address window
        for (int n = 0; n < 300; n++) begin
            op_in = 11'($urandom()); format_in = 3'($urandom());
            imm_in = 18'($urandom()); rt_addr_in = 7'($urandom());
            reg_write_in = 1'($urandom());
            ra_addr_in = 7'($urandom_range(0, 15));
            rb_addr_in = 7'($urandom_range(0, 15));
            rc_addr_in = 7'($urandom_range(0, 15));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            for (int t = 0; t < FWD_DEPTH; t++) begin
                fwd_data[t] = rnd128();
                fwd_addr[t] = 7'($urandom_range(0, 15));
                fwd_valid[t] = ($urandom_range(0, 3) == 0);
            end
            rt_wb_even = rnd128(); rt_wb_odd = rnd128();
            rt_addr_wb_even = 7'($urandom_range(0, 15));
            rt_addr_wb_odd = 7'($urandom_range(0, 15));
            reg_write_wb_even = 1'($urandom());
            reg_write_wb_odd = 1'($urandom());
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_fetch.md
# register_fetch

Register-fetch/forward stage of the SPU pipeline. It sits between decode and the execution units (SimpleFixed1 and peers). It holds the 128×128-bit register file and takes both write-back ports. It resolves RA/RB/RC operands through a forwarding network and presents a registered operand bundle (op, format, rt_addr, ra, rb, rc, imm, reg_write) to the execute stage one cycle later.

## Interface
- FWD_DEPTH, 7, number of in-flight result taps from execution stages
- REG_COUNT, 128, architectural registers; address width 7
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- op_in / format_in / imm_in  in  11 / 3 / 18  decoded instruction fields
- rt_addr_in, ra_addr_in, rb_addr_in, rc_addr_in  in  7 each  register addresses
- reg_write_in  in  1  decoded instr writes RT
- stall  in  1  hold output bundle
- flush  in  1  replace next output with NOP
- fwd_data[FWD_DEPTH]  in  128 each  execution-stage results; index 0 youngest
- fwd_addr[FWD_DEPTH]  in  7 each  destination of each tap
- fwd_valid[FWD_DEPTH]  in  1 each  tap holds a completed result
- rt_wb_even, rt_wb_odd  in  128  write-back data, even/odd pipe
- rt_addr_wb_even, rt_addr_wb_odd  in  7  write-back addresses
- reg_write_wb_even, reg_write_wb_odd  in  1  write enables
- op, format, rt_addr, imm, reg_write  out  11/3/7/18/1  registered to execute
- ra, rb, rc  out  128  registered resolved operands

## Operation
- RF: 128 entries × 128 b, all zero after reset; register 0 is ordinary (not hardwired).
- Writes on rising clk when reg_write_wb_* = 1. When both ports target the same address, odd wins.
- Operand resolution per source (RA, RB, RC), highest priority first:
  - fwd tap 0..FWD_DEPTH-1 with fwd_valid and address match (lowest index wins)
  - odd WB port (enable and match)
  - even WB port
  - RF read
- WB bypass means a write in cycle N is visible to an operand captured in cycle N.
- Output register load:
  - flush = 1: op=0, reg_write=0, rt_addr=0, ra/rb/rc=0, format=0, imm=0. Flush overrides stall.
  - else stall = 1: all outputs hold.
  - else: capture the decoded fields and resolved operands.
- WB writes proceed during stall and flush.
- Operands held under stall are not re-resolved. The hazard unit guarantees their correctness.
- No internal FSM beyond the output register. Validity is carried by reg_write/op (op=0 is NOP).

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Reset asserted (async, any time): all outputs 0 and RF zeroed immediately. State stays so until the first rising edge with reset high.
- Reset mid-stall or mid-flush: reset dominates.
- Write port timing: RF update and bypass share the same edge. No read-after-write bubble.
- Combinational path: fwd/WB inputs → priority mux → output flop. Keep the mux one level per source; no path to outputs bypasses the flop.

## Structure
- spu_pkg holds the shared definitions:
  - widths: WORD_W=128, ADDR_W=7, OP_W=11, IMM_W=18, FMT_W=3
  - OP_NOP constant
  - fwd_tap_t struct {data, addr, valid}
- Sub-module reg_file_128x128: async-active-low-reset storage, 2 write ports, 3 combinational read ports, odd-over-even write conflict rule.
- register_fetch adds the forwarding muxes and output register.

## Test plan
- Reset: drop reset low mid-cycle → all outputs 0 immediately. Reading r3 after release → ra=0.
- RF write/read: write r3=128'h0001…0001 via even WB. Next cycle ra_addr_in=3 → ra=128'h0001…0001 one cycle later.
- Same-cycle bypass and conflict:
  - even writes r5=A while odd writes r5=B, with rb_addr_in=5 in the same cycle → rb=B.
  - a later read of r5 → B.
- Forward priority: r7=C in RF; fwd tap 4 holds (7,D) and tap 1 holds (7,E), both valid → ra=E. Deassert tap 1 valid → ra=D.
- Stall/flush:
  - stall held 3 cycles while WB writes r9 → outputs unchanged throughout.
  - stall+flush together → op=0, reg_write=0 next cycle.
- Three sources: ra/rb/rc addresses 1/1/2, with fwd tap 0 valid for r2 → ra=rb=RF[1], rc=tap0 data.
